// File: rtl/isfet_pkg.sv
// Shared ISFET datapath definitions: sample/word geometry, pad value,
// packer FSM states and the lane-insert helper.
package isfet_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 256;
    localparam int LANES    = 16;
    localparam int CNT_W    = 4;

    localparam logic [SAMPLE_W-1:0] PAD_VALUE = 16'h0000;
    localparam logic [CNT_W-1:0]    LAST_LANE = 4'd15;
    localparam logic [WORD_W-1:0]   EMPTY_WORD = {LANES{PAD_VALUE}};

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        RUN      = 2'd1,
        FLUSH    = 2'd2
    } pk_state_e;

    // Lane k occupies bits [16k+15:16k]; {lane, 4'b0000} is k*16.
    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0]   word,
        input logic [CNT_W-1:0]    lane,
        input logic [SAMPLE_W-1:0] sample
    );
        logic [WORD_W-1:0] w;
        w = word;
        w[{lane, 4'b0000} +: SAMPLE_W] = sample;
        return w;
    endfunction

endpackage

// File: rtl/sample_packer_16to256.sv
// Packs 16-bit ISFET samples into 256-bit FIFO words through an assembly
// register and a single hold register; in_last closes a frame early.
module sample_packer_16to256
    import isfet_pkg::*;
(
    input  logic                clk,
    input  logic                rst_int,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                fifo_rdy,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [WORD_W-1:0]   fifo_din,
    output logic [31:0]         words_written,
    output logic [15:0]         partial_words,
    output logic                lost_flag
);

    pk_state_e          state_r, state_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [WORD_W-1:0]  asm_r, asm_s, hold_r, hold_s, asm_fill_s;
    logic               hold_valid_r, hold_valid_s;
    logic               partial_inc_s, lost_set_s, accept_s, discard_s;
    logic [31:0]        words_written_r;
    logic [15:0]        partial_words_r;
    logic               lost_flag_r;

    assign in_ready   = (state_r == RUN) && !(hold_valid_r && (count_r == LAST_LANE));
    assign accept_s   = in_valid && in_ready;
    assign fifo_wr_en = hold_valid_r && fifo_rdy && !fifo_full;
    assign fifo_din   = hold_r;
    assign discard_s  = (state_r != WAIT_RDY) && !fifo_rdy;

    assign words_written = words_written_r;
    assign partial_words = partial_words_r;
    assign lost_flag     = lost_flag_r;

    // Next-state, assembly/hold datapath and event strobes.
    always_comb begin
        state_s       = state_r;
        count_s       = count_r;
        asm_s         = asm_r;
        hold_s        = hold_r;
        hold_valid_s  = hold_valid_r && !fifo_wr_en;
        partial_inc_s = 1'b0;
        lost_set_s    = 1'b0;
        asm_fill_s    = lane_insert(asm_r, count_r, in_data);

        if (discard_s) begin
            state_s      = WAIT_RDY;
            count_s      = '0;
            asm_s        = EMPTY_WORD;
            hold_s       = EMPTY_WORD;
            hold_valid_s = 1'b0;
            lost_set_s   = hold_valid_r || (count_r != 4'd0);
        end else begin
            case (state_r)
                WAIT_RDY: begin
                    if (fifo_rdy) begin
                        state_s = RUN;
                    end else begin
                        state_s = WAIT_RDY;
                    end
                end
                RUN: begin
                    if (!accept_s) begin
                        state_s = RUN;
                    end else if ((count_r == LAST_LANE) || (in_last && !hold_valid_r)) begin
                        // Unwritten lanes of asm_r are already PAD_VALUE.
                        hold_s        = asm_fill_s;
                        hold_valid_s  = 1'b1;
                        asm_s         = EMPTY_WORD;
                        count_s       = '0;
                        partial_inc_s = in_last && (count_r != LAST_LANE);
                    end else begin
                        asm_s   = asm_fill_s;
                        count_s = count_r + 4'd1;
                        if (in_last) begin
                            state_s = FLUSH;
                        end else begin
                            state_s = RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (!hold_valid_r) begin
                        hold_s        = asm_r;
                        hold_valid_s  = 1'b1;
                        asm_s         = EMPTY_WORD;
                        count_s       = '0;
                        partial_inc_s = 1'b1;
                        state_s       = RUN;
                    end else begin
                        state_s = FLUSH;
                    end
                end
                default: begin
                    state_s      = WAIT_RDY;
                    count_s      = '0;
                    asm_s        = EMPTY_WORD;
                    hold_s       = EMPTY_WORD;
                    hold_valid_s = 1'b0;
                end
            endcase
        end
    end

    // FSM, assembly and hold registers.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_r      <= WAIT_RDY;
            count_r      <= '0;
            asm_r        <= EMPTY_WORD;
            hold_r       <= EMPTY_WORD;
            hold_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            asm_r        <= asm_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
        end
    end

    // Status counters and the sticky loss flag.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            words_written_r <= 32'd0;
            partial_words_r <= 16'd0;
            lost_flag_r     <= 1'b0;
        end else begin
            if (fifo_wr_en) begin
                words_written_r <= words_written_r + 32'd1;
            end
            if (partial_inc_s) begin
                partial_words_r <= partial_words_r + 16'd1;
            end
            if (lost_set_s) begin
                lost_flag_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_packer_16to256.sv
// Self-checking bench for sample_packer_16to256: directed scenarios plus a
// randomized run scored against a frame-level reference model.
module tb_sample_packer_16to256;

    logic         clk = 1'b0;
    logic         rst_int;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         in_last;
    logic         in_ready;
    logic         fifo_rdy;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [255:0] fifo_din;
    logic [31:0]  words_written;
    logic [15:0]  partial_words;
    logic         lost_flag;

    int checks = 0;
    int errors = 0;

    // Reference model state, owned by the monitor process.
    logic [15:0]  frame[$];
    logic [255:0] pending[$];
    logic [255:0] exp_log[$];
    logic [255:0] wr_log[$];
    int           exp_written = 0;
    int           exp_partial = 0;
    bit           exp_lost = 1'b0;

    int           chk_idx = 0;

    always #5 clk = ~clk;

    sample_packer_16to256 dut (
        .clk           (clk),
        .rst_int       (rst_int),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .fifo_rdy      (fifo_rdy),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .words_written (words_written),
        .partial_words (partial_words),
        .lost_flag     (lost_flag)
    );

    function automatic logic [255:0] pack(input logic [15:0] s[$]);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < s.size(); i++) begin
            w[i*16 +: 16] = s[i];
        end
        return w;
    endfunction

    // Model: a frame closes after 16 samples or on in_last; anything not yet
    // written when fifo_rdy drops is lost.
    always @(negedge clk) begin
        if (rst_int) begin
            frame.delete();
            pending.delete();
            exp_written = 0;
            exp_partial = 0;
            exp_lost    = 1'b0;
        end else begin
            if (fifo_wr_en) begin
                wr_log.push_back(fifo_din);
                if (pending.size() > 0) exp_log.push_back(pending.pop_front());
                else                    exp_log.push_back('x);
            end
            if (!fifo_rdy) begin
                if (frame.size() > 0 || pending.size() > 0) exp_lost = 1'b1;
                exp_written = exp_written - pending.size();
                frame.delete();
                pending.delete();
            end else if (in_valid && in_ready) begin
                frame.push_back(in_data);
                if (frame.size() == 16 || in_last) begin
                    pending.push_back(pack(frame));
                    exp_written++;
                    if (frame.size() < 16) exp_partial++;
                    frame.delete();
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h not accepted within 200 cycles", d);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (pending.size() > 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (pending.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout %0d words still pending", pending.size());
        end
        while (chk_idx < wr_log.size()) begin
            checks++;
            if (wr_log[chk_idx] !== exp_log[chk_idx]) begin
                errors++;
                $display("FAIL word%0d got %h exp %h", chk_idx, wr_log[chk_idx], exp_log[chk_idx]);
            end
            chk_idx++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)         begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (fifo_wr_en !== 1'b0)       begin errors++; $display("FAIL rst_wr_en got %b exp 0", fifo_wr_en); end
        checks++; if (fifo_din !== 256'd0)       begin errors++; $display("FAIL rst_din got %h exp 0", fifo_din); end
        checks++; if (words_written !== 32'd0)   begin errors++; $display("FAIL rst_words got %0d exp 0", words_written); end
        checks++; if (partial_words !== 16'd0)   begin errors++; $display("FAIL rst_partial got %0d exp 0", partial_words); end
        checks++; if (lost_flag !== 1'b0)        begin errors++; $display("FAIL rst_lost got %b exp 0", lost_flag); end
        rst_int = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int base;
        logic [255:0] w;
        logic [15:0] lo, hi;
        base = wr_log.size();
        fifo_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(16'(i), 1'b0);
            if (i == 15) begin
                checks++;
                if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL latency_wr_en got %b exp 1", fifo_wr_en); end
            end
        end
        drain();
        checks++;
        if (wr_log.size() - base != 2) begin
            errors++; $display("FAIL stream_writes got %0d exp 2", wr_log.size() - base);
        end else begin
            w  = wr_log[base];
            lo = w[15:0];
            hi = w[255:240];
            checks++; if (lo !== 16'h0000) begin errors++; $display("FAIL stream_lane0 got %h exp 0000", lo); end
            checks++; if (hi !== 16'h000F) begin errors++; $display("FAIL stream_lane15 got %h exp 000f", hi); end
        end
        checks++; if (words_written !== 32'd2) begin errors++; $display("FAIL stream_count got %0d exp 2", words_written); end
    endtask

    task automatic test_partial();
        int base;
        logic [255:0] exp_w;
        base  = wr_log.size();
        exp_w = {176'd0, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001};
        for (int i = 1; i <= 5; i++) send(16'hA000 + 16'(i), i == 5);
        drain();
        checks++;
        if (wr_log.size() - base != 1) begin
            errors++; $display("FAIL partial_writes got %0d exp 1", wr_log.size() - base);
        end else begin
            checks++;
            if (wr_log[base] !== exp_w) begin errors++; $display("FAIL partial_word got %h exp %h", wr_log[base], exp_w); end
        end
        checks++; if (partial_words !== 16'd1) begin errors++; $display("FAIL partial_count got %0d exp 1", partial_words); end
    endtask

    task automatic test_full();
        int base, acc;
        base      = wr_log.size();
        acc       = 0;
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_data = 16'hB000 + 16'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (acc != 31)          begin errors++; $display("FAIL full_accepts got %0d exp 31", acc); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en got %b exp 0", fifo_wr_en); end
        fifo_full = 1'b0;
        send(16'hB000 + 16'(acc), 1'b0);
        drain();
        checks++; if (wr_log.size() - base != 2) begin errors++; $display("FAIL full_writes got %0d exp 2", wr_log.size() - base); end
        checks++; if (lost_flag !== 1'b0)        begin errors++; $display("FAIL full_lost got %b exp 0", lost_flag); end
    endtask

    task automatic test_flush();
        int base;
        base      = wr_log.size();
        fifo_full = 1'b1;
        for (int i = 0; i < 16; i++) send(16'hC000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++)  send(16'hC100 + 16'(i), 1'b0);
        send(16'hC103, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_hold got %b exp 0", in_ready); end
        fifo_full = 1'b0;
        drain();
        checks++; if (wr_log.size() - base != 2) begin errors++; $display("FAIL flush_writes got %0d exp 2", wr_log.size() - base); end
        checks++; if (partial_words !== 16'd2)   begin errors++; $display("FAIL flush_partial got %0d exp 2", partial_words); end
        checks++; if (in_ready !== 1'b1)         begin errors++; $display("FAIL flush_back_run got %b exp 1", in_ready); end
    endtask

    task automatic test_lost();
        logic [31:0] ww;
        for (int i = 0; i < 7; i++) send(16'hD000 + 16'(i), 1'b0);
        ww       = words_written;
        fifo_rdy = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (lost_flag !== 1'b1) begin errors++; $display("FAIL lost_flag got %b exp 1", lost_flag); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL lost_in_ready got %b exp 0", in_ready); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (words_written !== ww) begin errors++; $display("FAIL lost_no_write got %0d exp %0d", words_written, ww); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL lost_wait got %b exp 0", in_ready); end
        fifo_rdy = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lost_recover got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        fifo_full = 1'b1;
        for (int i = 0; i < 20; i++) send(16'hE000 + 16'(i), 1'b0);
        rst_int = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)       begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        checks++; if (fifo_wr_en !== 1'b0)     begin errors++; $display("FAIL midrst_wr_en got %b exp 0", fifo_wr_en); end
        checks++; if (fifo_din !== 256'd0)     begin errors++; $display("FAIL midrst_din got %h exp 0", fifo_din); end
        checks++; if (words_written !== 32'd0) begin errors++; $display("FAIL midrst_words got %0d exp 0", words_written); end
        checks++; if (partial_words !== 16'd0) begin errors++; $display("FAIL midrst_partial got %0d exp 0", partial_words); end
        checks++; if (lost_flag !== 1'b0)      begin errors++; $display("FAIL midrst_lost got %b exp 0", lost_flag); end
        @(posedge clk);
        #1;
        rst_int   = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int sent;
        logic [15:0] cur;
        bit cur_last;
        sent     = 0;
        cur      = 16'($urandom);
        cur_last = ($urandom_range(0, 7) == 0);
        for (int c = 0; c < 4000 && sent < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            in_data   = cur;
            in_last   = cur_last;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                cur      = 16'($urandom);
                cur_last = ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        send(16'h1234, 1'b1);
        drain();
        checks++; if (words_written !== 32'(exp_written)) begin errors++; $display("FAIL rand_words got %0d exp %0d", words_written, exp_written); end
        checks++; if (partial_words !== 16'(exp_partial)) begin errors++; $display("FAIL rand_partial got %0d exp %0d", partial_words, exp_partial); end
        checks++; if (lost_flag !== exp_lost)             begin errors++; $display("FAIL rand_lost got %b exp %b", lost_flag, exp_lost); end
    endtask

    initial begin
        rst_int   = 1'b1;
        fifo_rdy  = 1'b0;
        fifo_full = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        test_reset();
        test_stream();
        test_partial();
        test_full();
        test_flush();
        test_lost();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
